fft_twiddle_sequencer: RTL

//  Control sequencer for the 8-point radix-2 DIT FFT datapath. On start it

---
 rtl/fft_twiddle_sequencer_if.sv | 22 ++
 rtl/fft_twiddle_sequencer.sv | 112 +++++++++++
 2 files changed

// File: rtl/fft_twiddle_sequencer_if.sv
// rtl/fft_twiddle_sequencer_if.sv - control/issue bundle between FFT top control and the twiddle sequencer
interface fft_twiddle_sequencer_if;
    logic       start;
    logic [2:0] tw_index;
    logic       tw_req;
    logic       bf_valid;
    logic [2:0] bf_addr_a;
    logic [2:0] bf_addr_b;
    logic [1:0] bf_stage;
    logic       busy;
    logic       done;

    modport master (
        output start,
        input  tw_index, tw_req, bf_valid, bf_addr_a, bf_addr_b, bf_stage, busy, done
    );

    modport slave (
        input  start,
        output tw_index, tw_req, bf_valid, bf_addr_a, bf_addr_b, bf_stage, busy, done
    );
endinterface

// File: rtl/fft_twiddle_sequencer.sv
// rtl/fft_twiddle_sequencer.sv - 8-point radix-2 DIT FFT stage/butterfly issue sequencer
module fft_twiddle_sequencer #(
    parameter int ROM_LAT = 2,
    parameter int BF_LAT  = 3
) (
    input  logic                     clk,
    input  logic                     rst,
    fft_twiddle_sequencer_if.slave   bus
);
    localparam int D  = ROM_LAT + BF_LAT;
    localparam int CW = (D < 1) ? 1 : $clog2(D + 1);

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

    typedef struct packed {
        logic       v;
        logic [2:0] a;
        logic [2:0] b;
        logic [1:0] s;
    } ent_t;

    state_t         state;
    logic [1:0]     k;
    logic [1:0]     s;
    logic [CW-1:0]  cnt;
    logic [2:0]     tw_index_r;
    logic           busy_r;
    logic           done_r;
    ent_t           pipe [0:ROM_LAT];

    logic [2:0] k3, span, lo, a_c, b_c, tw_c;

    // Butterfly operand/twiddle addressing for stage s, butterfly k.
    always_comb begin
        k3   = {1'b0, k};
        span = 3'd1 << s;
        lo   = k3 & (span - 3'd1);
        a_c  = ((k3 >> s) << (s + 2'd1)) + lo;
        b_c  = a_c + span;
        tw_c = lo << (2'd2 - s);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            k          <= '0;
            s          <= '0;
            cnt        <= '0;
            tw_index_r <= '0;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
        end else begin
            busy_r <= (state == ISSUE) || (state == DRAIN);
            done_r <= (state == DONE);
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        state <= ISSUE;
                        k     <= '0;
                        s     <= '0;
                    end
                end
                ISSUE: begin
                    tw_index_r <= tw_c;
                    k          <= k + 2'd1;
                    if (k == 2'd3) begin
                        state <= DRAIN;
                        cnt   <= '0;
                    end
                end
                DRAIN: begin
                    cnt <= cnt + 1'b1;
                    // Wait out ROM read plus butterfly write-back before the next stage reads RAM.
                    if (cnt == CW'(D - 1)) begin
                        cnt <= '0;
                        if (s == 2'd2) begin
                            state <= DONE;
                        end else begin
                            s     <= s + 2'd1;
                            state <= ISSUE;
                        end
                    end
                end
                DONE: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // Stage 0 is the issue register; stage ROM_LAT lines up with the ROM output.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i <= ROM_LAT; i++) pipe[i] <= '0;
        end else begin
            if (state == ISSUE) pipe[0] <= '{v: 1'b1, a: a_c, b: b_c, s: s};
            else                pipe[0].v <= 1'b0;
            for (int i = 1; i <= ROM_LAT; i++) begin
                if (pipe[i-1].v) pipe[i] <= pipe[i-1];
                else             pipe[i].v <= 1'b0;
            end
        end
    end

    assign bus.tw_index  = tw_index_r;
    assign bus.tw_req    = pipe[0].v;
    assign bus.bf_valid  = pipe[ROM_LAT].v;
    assign bus.bf_addr_a = pipe[ROM_LAT].a;
    assign bus.bf_addr_b = pipe[ROM_LAT].b;
    assign bus.bf_stage  = pipe[ROM_LAT].s;
    assign bus.busy      = busy_r;
    assign bus.done      = done_r;
endmodule
